// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding
// and the terminal status codes reported on o_status.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_NEXT = 3'd4,
        S_STOP = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE     = 2'b00,
        ST_OVF      = 2'b01,
        ST_TIMEOUT  = 2'b10,
        ST_MISALIGN = 2'b11
    } status_t;

    // Word alignment test on the two low address bits.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Decode-side holding register: captures a fetched word and keeps it and its
// valid flag stable until decode accepts it.
module fetch_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_accept
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_accept = valid_q & i_ready;

    // Next-state: load wins, otherwise a handshake drops valid; data is kept.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (i_load) begin
            data_d  = i_data;
            valid_d = 1'b1;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: samples the PC, issues one request to instruction
// memory, waits (bounded) for the response and hands the word to decode.
// Optional build macro FETCH_ALIGN_CHECK_EN stops the fetch with status 11
// when the PC is not word aligned.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_pc_overflow,
    input  logic                  i_pc_update,
    output logic                  o_imem_req,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_valid,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [1:0]            o_status,
    output logic                  o_status_valid
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  req_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    status_t               status_q;
    logic                  status_valid_q;
    logic                  pending_q;
    logic                  load;
    logic                  accept;

    assign cnt_d = cnt_q + CNT_W'(1);
    assign load  = (state_q == S_WAIT) && i_imem_valid;

    assign o_imem_req     = req_q;
    assign o_imem_addr    = addr_q;
    assign o_status       = status_q;
    assign o_status_valid = status_valid_q;

    fetch_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (load),
        .i_data   (i_imem_rdata),
        .i_ready  (i_inst_ready),
        .o_data   (o_inst),
        .o_valid  (o_inst_valid),
        .o_accept (accept)
    );

    // Fetch FSM with wait counter, request strobe and status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            addr_q         <= '0;
            status_q       <= ST_NONE;
            status_valid_q <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            req_q          <= 1'b0;
            status_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) state_q <= S_REQ;
                end
                S_REQ: begin
                    pending_q <= 1'b0;
                    if (i_pc_overflow) begin
                        status_q       <= ST_OVF;
                        status_valid_q <= 1'b1;
                        state_q        <= S_STOP;
                    end
`ifdef FETCH_ALIGN_CHECK_EN
                    else if (!is_aligned(i_pc[1:0])) begin
                        status_q       <= ST_MISALIGN;
                        status_valid_q <= 1'b1;
                        state_q        <= S_STOP;
                    end
`endif
                    else begin
                        addr_q  <= i_pc;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the limit cycle still wins.
                    if (i_imem_valid) begin
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_LIMIT) begin
                            status_q       <= ST_TIMEOUT;
                            status_valid_q <= 1'b1;
                            state_q        <= S_STOP;
                        end
                    end
                end
                S_HOLD: begin
                    // An early PC update is remembered until decode accepts.
                    if (accept) begin
                        pending_q <= 1'b0;
                        state_q   <= (i_pc_update || pending_q) ? S_REQ : S_NEXT;
                    end else if (i_pc_update) begin
                        pending_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (i_pc_update) state_q <= S_REQ;
                end
                S_STOP: begin
                    state_q <= S_STOP;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
